// File: rtl/apb_modport.sv
// APB register block that runs a simple countdown "transfer" engine with done interrupt.
// Zero-wait-state slave: every enabled access completes in the cycle it is presented.
module apb_modport (
    input  logic        clk,
    input  logic        reset,
    input  logic        pclken,
    input  logic        psel,
    input  logic        penable,
    input  logic [12:0] paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    input  logic        scan_en,
    output logic [31:0] prdata,
    output logic        pslverr,
    output logic        pready,
    output logic        idle,
    output logic        INT
);

    localparam logic [31:0] ID_VALUE = 32'hDA1A0001;

    localparam logic [2:0] IDX_START    = 3'd0;
    localparam logic [2:0] IDX_SRC      = 3'd1;
    localparam logic [2:0] IDX_DST      = 3'd2;
    localparam logic [2:0] IDX_LEN      = 3'd3;
    localparam logic [2:0] IDX_STATUS   = 3'd4;
    localparam logic [2:0] IDX_INT_EN   = 3'd5;
    localparam logic [2:0] IDX_INT_STAT = 3'd6;
    localparam logic [2:0] IDX_ID       = 3'd7;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        w_busy;

    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [15:0] r_len;
    logic        r_intEn;
    logic        r_done;
    logic [15:0] r_remaining;

    logic        w_access;
    logic        w_mapped;
    logic [2:0]  w_idx;
    logic        w_wrEn;
    logic        w_startReq;
    logic        w_startOk;
    logic        w_startRej;
    logic        w_finish;
    logic [31:0] w_rdData;

    assign w_access   = pclken & psel & penable;
    assign w_mapped   = (paddr[12:5] == 8'd0);
    assign w_idx      = paddr[4:2];
    // scan_en suppresses every register write, including START and W1C
    assign w_wrEn     = w_access & pwrite & w_mapped & ~scan_en;
    assign w_startReq = w_wrEn && (w_idx == IDX_START) && pwdata[0];
    assign w_startOk  = w_startReq && !w_busy && (r_len != 16'd0);
    assign w_startRej = w_startReq && !w_startOk;
    assign w_finish   = w_busy && !scan_en && (r_remaining == 16'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (w_startOk) w_nextState = ST_BUSY;
            ST_BUSY: if (w_finish)  w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            ST_BUSY: w_busy = 1'b1;
            default: w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_remaining <= '0;
        end else if (w_startOk) begin
            r_remaining <= r_len;
        end else if (w_busy && !scan_en) begin
            r_remaining <= r_remaining - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_intEn <= 1'b0;
        end else if (w_wrEn) begin
            case (w_idx)
                IDX_SRC:    r_src   <= pwdata;
                IDX_DST:    r_dst   <= pwdata;
                IDX_LEN:    r_len   <= pwdata[15:0];
                IDX_INT_EN: r_intEn <= pwdata[0];
                default:    ;
            endcase
        end
    end

    // Completion has priority over a simultaneous W1C so no done event is lost
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
        end else if (w_finish) begin
            r_done <= 1'b1;
        end else if (w_wrEn && (w_idx == IDX_INT_STAT) && pwdata[0]) begin
            r_done <= 1'b0;
        end
    end

    always_comb begin
        w_rdData = '0;
        if (w_mapped) begin
            case (w_idx)
                IDX_SRC:      w_rdData = r_src;
                IDX_DST:      w_rdData = r_dst;
                IDX_LEN:      w_rdData = {16'd0, r_len};
                IDX_STATUS:   w_rdData = {r_remaining, 15'd0, w_busy};
                IDX_INT_EN:   w_rdData = {31'd0, r_intEn};
                IDX_INT_STAT: w_rdData = {31'd0, r_done};
                IDX_ID:       w_rdData = ID_VALUE;
                default:      w_rdData = '0;
            endcase
        end
    end

    always_comb begin
        pslverr = 1'b0;
        if (w_access) begin
            if (!w_mapped) begin
                pslverr = 1'b1;
            end else if (pwrite && !scan_en) begin
                if ((w_idx == IDX_STATUS) || (w_idx == IDX_ID) || w_startRej) begin
                    pslverr = 1'b1;
                end
            end
        end
    end

    assign prdata = (w_access && !pwrite) ? w_rdData : '0;
    assign pready = w_access;
    assign idle   = ~w_busy;
    assign INT    = r_done & r_intEn;

endmodule

// File: tb/tb_apb_modport.sv
// Self-checking bench for apb_modport: directed vector table, multi-cycle sequences,
// and a randomized register-access phase checked against an address-map model.
module tb_apb_modport;

    localparam logic [31:0] ID_VALUE = 32'hDA1A0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        pclken;
    logic        psel;
    logic        penable;
    logic [12:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        scan_en;
    logic [31:0] prdata;
    logic        pslverr;
    logic        pready;
    logic        idle;
    logic        INT;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        wr;
        logic [12:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRd;
        logic        expErr;
    } vector_t;

    vector_t vecs[$];

    logic [31:0] refMem [8];
    logic [31:0] rwMask [8];

    apb_modport dut (
        .clk     (clk),
        .reset   (reset),
        .pclken  (pclken),
        .psel    (psel),
        .penable (penable),
        .paddr   (paddr),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .scan_en (scan_en),
        .prdata  (prdata),
        .pslverr (pslverr),
        .pready  (pready),
        .idle    (idle),
        .INT     (INT)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Full two-phase APB transfer; returns at the falling edge after the commit edge
    task automatic applyStimulus(input logic wr, input logic [12:0] addr, input logic [31:0] data,
                                 output logic [31:0] rd, output logic err, output logic rdy);
        @(negedge clk);
        psel    = 1'b1;
        penable = 1'b0;
        pclken  = 1'b1;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(negedge clk);
        penable = 1'b1;
        #1;
        rd  = prdata;
        err = pslverr;
        rdy = pready;
        @(negedge clk);
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic accessNow(input logic wr, input logic [12:0] addr, input logic [31:0] data);
        psel    = 1'b1;
        penable = 1'b1;
        pclken  = 1'b1;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
    endtask

    task automatic idleBus();
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        for (int c = 0; c < budget && idle !== 1'b1; c++) @(negedge clk);
        #1;
        checkOutput("waitIdle idle", {31'd0, idle}, 32'd1);
    endtask

    function automatic logic [31:0] modelRead(input int idx);
        if (idx == 7) return ID_VALUE;
        return refMem[idx];
    endfunction

    initial begin
        logic [31:0] rd;
        logic        err;
        logic        rdy;

        reset   = 1'b1;
        pclken  = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        scan_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset idle", {31'd0, idle}, 32'd1);
        checkOutput("reset INT", {31'd0, INT}, 32'd0);
        checkOutput("reset prdata", prdata, 32'd0);
        checkOutput("reset pready", {31'd0, pready}, 32'd0);
        checkOutput("reset pslverr", {31'd0, pslverr}, 32'd0);
        reset = 1'b0;

        vecs.push_back('{1'b1, 13'h004, 32'h12345678, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 13'h004, 32'h00000000, 32'h12345678, 1'b0});
        vecs.push_back('{1'b1, 13'h008, 32'hCAFEBABE, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 13'h008, 32'h00000000, 32'hCAFEBABE, 1'b0});
        vecs.push_back('{1'b1, 13'h00C, 32'hFFFF0004, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 13'h00C, 32'h00000000, 32'h00000004, 1'b0});
        vecs.push_back('{1'b1, 13'h014, 32'hFFFFFFFF, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 13'h014, 32'h00000000, 32'h00000001, 1'b0});
        vecs.push_back('{1'b0, 13'h01C, 32'h00000000, ID_VALUE,     1'b0});
        vecs.push_back('{1'b1, 13'h01C, 32'h00000000, 32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 13'h01C, 32'h00000000, ID_VALUE,     1'b0});
        vecs.push_back('{1'b0, 13'h100, 32'h00000000, 32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 13'h010, 32'h0000FFFF, 32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 13'h010, 32'h00000000, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 13'h000, 32'h00000000, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 13'h007, 32'h00000000, 32'h12345678, 1'b0});
        vecs.push_back('{1'b1, 13'h020, 32'h00000001, 32'h00000000, 1'b1});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, rdy);
            checkOutput($sformatf("vec%0d prdata", i), rd, vecs[i].expRd);
            checkOutput($sformatf("vec%0d pslverr", i), {31'd0, err}, {31'd0, vecs[i].expErr});
            checkOutput($sformatf("vec%0d pready", i), {31'd0, rdy}, 32'd1);
        end

        // Access with pclken low is not a transfer and must not commit
        accessNow(1'b1, 13'h004, 32'hDEADBEEF);
        pclken = 1'b0;
        #1;
        checkOutput("pclken0 pready", {31'd0, pready}, 32'd0);
        checkOutput("pclken0 pslverr", {31'd0, pslverr}, 32'd0);
        @(negedge clk);
        pwrite = 1'b0;
        paddr  = 13'h01C;
        #1;
        checkOutput("pclken0 prdata", prdata, 32'd0);
        @(negedge clk);
        idleBus();
        pclken = 1'b1;
        applyStimulus(1'b0, 13'h004, 32'd0, rd, err, rdy);
        checkOutput("pclken0 no commit", rd, 32'h12345678);

        // LEN=4 transfer with interrupt enabled
        applyStimulus(1'b1, 13'h000, 32'd1, rd, err, rdy);
        checkOutput("start4 pslverr", {31'd0, err}, 32'd0);
        checkOutput("start4 pready", {31'd0, rdy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            accessNow(1'b0, 13'h010, 32'd0);
            #1;
            checkOutput($sformatf("len4 idle c%0d", i), {31'd0, idle}, 32'd0);
            checkOutput($sformatf("len4 remaining c%0d", i), {16'd0, prdata[31:16]}, 32'(4 - i));
            checkOutput($sformatf("len4 busy c%0d", i), {31'd0, prdata[0]}, 32'd1);
            @(negedge clk);
        end
        idleBus();
        #1;
        checkOutput("len4 done idle", {31'd0, idle}, 32'd1);
        checkOutput("len4 done INT", {31'd0, INT}, 32'd1);

        applyStimulus(1'b1, 13'h018, 32'd1, rd, err, rdy);
        #1;
        checkOutput("w1c INT", {31'd0, INT}, 32'd0);
        applyStimulus(1'b0, 13'h018, 32'd0, rd, err, rdy);
        checkOutput("w1c readback", rd, 32'd0);

        applyStimulus(1'b1, 13'h00C, 32'd0, rd, err, rdy);
        applyStimulus(1'b1, 13'h000, 32'd1, rd, err, rdy);
        checkOutput("start len0 pslverr", {31'd0, err}, 32'd1);
        #1;
        checkOutput("start len0 idle", {31'd0, idle}, 32'd1);
        applyStimulus(1'b0, 13'h010, 32'd0, rd, err, rdy);
        checkOutput("start len0 status", rd, 32'd0);

        // LEN=8 transfer frozen by scan_en for three edges
        applyStimulus(1'b1, 13'h00C, 32'd8, rd, err, rdy);
        applyStimulus(1'b1, 13'h000, 32'd1, rd, err, rdy);
        checkOutput("start8 pslverr", {31'd0, err}, 32'd0);
        scan_en = 1'b1;
        accessNow(1'b0, 13'h010, 32'd0);
        #1;
        checkOutput("scan status0", prdata, 32'h00080001);
        @(negedge clk);
        accessNow(1'b1, 13'h004, 32'hBAD0BAD0);
        #1;
        checkOutput("scan write pslverr", {31'd0, pslverr}, 32'd0);
        checkOutput("scan write pready", {31'd0, pready}, 32'd1);
        @(negedge clk);
        accessNow(1'b0, 13'h010, 32'd0);
        #1;
        checkOutput("scan status2", prdata, 32'h00080001);
        @(negedge clk);
        scan_en = 1'b0;
        #1;
        checkOutput("scan status3", prdata, 32'h00080001);
        @(negedge clk);
        #1;
        checkOutput("scan resumed", prdata, 32'h00070001);
        idleBus();
        waitIdle(40);
        checkOutput("len8 INT", {31'd0, INT}, 32'd1);
        applyStimulus(1'b0, 13'h004, 32'd0, rd, err, rdy);
        checkOutput("scan write ignored", rd, 32'h12345678);

        // Rejected START and LEN rewrite while busy leave the active count alone
        applyStimulus(1'b1, 13'h00C, 32'd12, rd, err, rdy);
        applyStimulus(1'b1, 13'h000, 32'd1, rd, err, rdy);
        checkOutput("start12 pslverr", {31'd0, err}, 32'd0);
        applyStimulus(1'b1, 13'h000, 32'd1, rd, err, rdy);
        checkOutput("start busy pslverr", {31'd0, err}, 32'd1);
        applyStimulus(1'b1, 13'h00C, 32'd3, rd, err, rdy);
        checkOutput("len busy pslverr", {31'd0, err}, 32'd0);
        applyStimulus(1'b0, 13'h010, 32'd0, rd, err, rdy);
        checkOutput("busy status", rd, 32'h00040001);
        applyStimulus(1'b0, 13'h100, 32'd0, rd, err, rdy);
        checkOutput("unmapped pslverr", {31'd0, err}, 32'd1);
        applyStimulus(1'b1, 13'h01C, 32'h0, rd, err, rdy);
        checkOutput("id write pslverr", {31'd0, err}, 32'd1);
        waitIdle(40);
        applyStimulus(1'b0, 13'h00C, 32'd0, rd, err, rdy);
        checkOutput("len after busy write", rd, 32'd3);

        // Reset in the middle of a transfer
        applyStimulus(1'b1, 13'h000, 32'd1, rd, err, rdy);
        #1;
        checkOutput("pre-reset idle", {31'd0, idle}, 32'd0);
        checkOutput("pre-reset INT", {31'd0, INT}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midreset idle", {31'd0, idle}, 32'd1);
        checkOutput("midreset INT", {31'd0, INT}, 32'd0);
        for (int a = 0; a < 8; a++) begin
            applyStimulus(1'b0, 13'(a * 4), 32'd0, rd, err, rdy);
            checkOutput($sformatf("midreset reg%0d", a), rd, (a == 7) ? ID_VALUE : 32'd0);
        end

        // Randomized accesses against an address-map model
        for (int i = 0; i < 8; i++) begin
            refMem[i] = '0;
            rwMask[i] = '0;
        end
        rwMask[1] = 32'hFFFFFFFF;
        rwMask[2] = 32'hFFFFFFFF;
        rwMask[3] = 32'h0000FFFF;
        rwMask[5] = 32'h00000001;
        for (int n = 0; n < 200; n++) begin
            int          kind;
            logic        wr;
            logic        sc;
            logic        mapped;
            logic [12:0] addr;
            logic [31:0] data;
            logic [31:0] expRd;
            logic        expErr;
            kind   = int'($urandom_range(0, 8));
            wr     = 1'($urandom_range(0, 1));
            sc     = ($urandom_range(0, 3) == 0);
            data   = $urandom;
            mapped = (kind != 8);
            if (mapped) begin
                addr = 13'(kind * 4 + int'($urandom_range(0, 3)));
                if (kind == 0 || kind == 6) wr = 1'b0;
            end else begin
                addr = 13'(int'($urandom_range(8, 2047)) * 4 + int'($urandom_range(0, 3)));
            end
            expErr = !mapped || (wr && !sc && (kind == 4 || kind == 7));
            expRd  = (wr || !mapped) ? 32'd0 : modelRead(kind);
            scan_en = sc;
            applyStimulus(wr, addr, data, rd, err, rdy);
            scan_en = 1'b0;
            checkOutput($sformatf("rand%0d prdata", n), rd, expRd);
            checkOutput($sformatf("rand%0d pslverr", n), {31'd0, err}, {31'd0, expErr});
            if (wr && mapped && !sc) refMem[kind] = data & rwMask[kind];
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/apb_modport.md
APB_MODPORT -- requirements
Module: apb_modport

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-002 The block SHALL provide these ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- pclken  input  1  APB clock enable; APB transfers are recognised only when 1
- psel  input  1  APB slave select
- penable  input  1  APB access phase
- paddr  input  13  byte address; paddr[1:0] ignored
- pwrite  input  1  1 = write, 0 = read
- pwdata  input  32  write data
- scan_en  input  1  test mode; blocks register writes and freezes the transfer counter
- prdata  output  32  read data
- pslverr  output  1  transfer error
- pready  output  1  transfer complete
- idle  output  1  no transfer in progress
- INT  output  1  interrupt request

Function
REQ-003 An access SHALL be defined as the cycle where pclken=1, psel=1 and penable=1.
REQ-004 pready SHALL be combinationally driven as psel & penable & pclken, giving zero wait states; otherwise it SHALL be 0.
REQ-005 prdata SHALL show the addressed register during a read access and SHALL be 0 at all other times.
REQ-006 pslverr SHALL be driven during an access only, and SHALL be 1 for any of: unmapped address, write to a read-only register, or rejected START.
REQ-007 A write SHALL commit on the rising edge that ends the access cycle.
REQ-008 The register map SHALL be:
- 0x000 START: write-only; reads 0. Writing pwdata[0]=1 starts a transfer.
- 0x004 SRC_ADDR: RW, 32 bits.
- 0x008 DST_ADDR: RW, 32 bits.
- 0x00C LEN: RW in [15:0]; [31:16] read 0.
- 0x010 STATUS: RO. [0]=busy; [31:16]=remaining count.
- 0x014 INT_EN: RW in [0].
- 0x018 INT_STAT: [0]=done; writing 1 clears it (W1C).
- 0x01C ID: RO, value 0xDA1A0001.
- Any other address SHALL read 0 and return pslverr=1.
REQ-009 A START write with busy=0 and LEN!=0 SHALL, on the next cycle, set busy=1 and load remaining=LEN.
REQ-010 A START write with LEN=0 or busy=1 SHALL be rejected, with pslverr=1 and no state change.
REQ-011 While busy=1 and scan_en=0, remaining SHALL decrement by 1 each clk cycle, independent of pclken.
REQ-012 When remaining reaches 0, busy SHALL clear and INT_STAT[0] SHALL set on that same edge, so busy is high for exactly LEN cycles.
REQ-013 If done-set and a W1C clear occur on the same edge, the set SHALL win.
REQ-014 idle SHALL equal ~busy, and INT SHALL equal INT_STAT[0] & INT_EN[0]; both SHALL be registered-state based with no combinational path from APB inputs.
REQ-015 With scan_en=1:
- writes SHALL be ignored without error;
- reads SHALL work normally;
- the counter SHALL hold its value.
REQ-016 Writes to SRC_ADDR, DST_ADDR and LEN while busy SHALL be accepted and SHALL NOT affect the active transfer.

Reset
REQ-017 While reset=1 at a rising edge, the block SHALL clear all registers, busy, remaining and INT_STAT to 0, setting idle=1 and INT=0.
REQ-018 Reset SHALL override any access or counter update in the same cycle, including mid-transfer.

Verification
REQ-019 Write SRC_ADDR=0x12345678, then read it back -> prdata=0x12345678, pslverr=0, pready=1.
REQ-020 LEN=4, INT_EN=1, START=1 -> idle=0 for exactly 4 cycles, STATUS reads 4,3,2,1 in bits [31:16], then idle=1 and INT=1.
REQ-021 Write 1 to INT_STAT after completion -> INT=0; a read of 0x018 returns 0.
REQ-022 START with LEN=0, then START while busy, then read of 0x100, then write to 0x01C -> pslverr=1 on each, with no state change.
REQ-023 Hold scan_en=1 during a LEN=8 transfer for 3 cycles -> remaining frozen; a write to SRC_ADDR during that window is ignored.
REQ-024 Assert reset mid-transfer -> next cycle idle=1, INT=0, and all registers read 0 except ID=0xDA1A0001.
